// File: rtl/lamp_pkg.sv
// lamp_pkg: shared arbiter encoding and default constants for the tail-light request path.
package lamp_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } arb_state_t;

    localparam logic [1:0] SEQ_LAST = 2'd2;

    localparam int STEP_DIV_D     = 16;
    localparam int DEB_CYCLES_D   = 4;
    localparam int PWM_BITS_D     = 4;
    localparam int DIM_DUTY_D     = 3;
    localparam int CANCEL_STEPS_D = 24;
endpackage

// File: rtl/lamp_debounce.sv
// lamp_debounce: 2-flop synchronizer followed by a consecutive-cycle debouncer for one switch.
module lamp_debounce
    import lamp_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_D
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_db
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_db;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db = r_db;
endmodule

// File: rtl/lamp_request_scheduler.sv
// lamp_request_scheduler: debounces tail-light switches, paces the pattern FSM and arbitrates turn/hazard ownership.
// Defining LAMP_AUTO_CANCEL_EN adds a turn auto-cancel with a per-side lockout.
module lamp_request_scheduler
    import lamp_pkg::*;
#(
    parameter int STEP_DIV   = STEP_DIV_D,
    parameter int DEB_CYCLES = DEB_CYCLES_D,
    parameter int PWM_BITS   = PWM_BITS_D,
    parameter int DIM_DUTY   = DIM_DUTY_D
`ifdef LAMP_AUTO_CANCEL_EN
    ,
    parameter int CANCEL_STEPS = CANCEL_STEPS_D
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left_in,
    input  logic       right_in,
    input  logic       brake_in,
    input  logic       hazard_in,
    input  logic       run_in,
    output logic       step_en,
    output logic       left,
    output logic       right,
    output logic       hazard,
    output logic       brake,
    output logic       run,
    output logic       dim_on,
    output logic [1:0] seq_pos
);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DB_L = 0, DB_R = 1, DB_B = 2, DB_H = 3, DB_RUN = 4;

    logic [4:0]          w_raw, w_db;
    logic [SW-1:0]       r_step_cnt;
    logic [PWM_BITS-1:0] r_pwm;
    logic                w_step, w_l, w_r, w_turn, w_eval_en, w_cancel;
    arb_state_t          r_state, w_eval, w_nxt;
    logic [1:0]          r_seq, w_seq_nxt;
    logic                r_step_en, r_left, r_right, r_hazard, r_brake, r_run, r_dim;

    assign w_raw = {run_in, hazard_in, brake_in, right_in, left_in};

    for (genvar g = 0; g < 5; g++) begin : g_deb
        lamp_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .rst  (rst),
            .i_raw(w_raw[g]),
            .o_db (w_db[g])
        );
    end

    assign w_step = r_step_cnt == SW'(STEP_DIV - 1);
    assign w_turn = r_state == LEFT || r_state == RIGHT;

    // A turn sweep only yields at its last step unless hazard preempts it.
    always_comb begin
        w_eval    = (w_db[DB_H] || (w_l && w_r)) ? HAZ : w_l ? LEFT : w_r ? RIGHT : IDLE;
        w_eval_en = w_step && (r_state == IDLE ||
                    (r_state == HAZ ? (!w_db[DB_H] && !(w_db[DB_L] && w_db[DB_R]))
                                    : (w_db[DB_H] || r_seq == SEQ_LAST)));
        w_nxt     = w_cancel ? IDLE : w_eval_en ? w_eval : r_state;
        w_seq_nxt = (w_cancel || w_eval_en) ? 2'd0 : (w_step && w_turn) ? r_seq + 2'd1 : r_seq;
    end

`ifdef LAMP_AUTO_CANCEL_EN
    localparam int CW = $clog2(CANCEL_STEPS + 1);

    logic [CW-1:0] r_turn_cnt;
    logic          r_lock_l, r_lock_r;

    assign w_l = w_db[DB_L] && !r_lock_l;
    assign w_r = w_db[DB_R] && !r_lock_r;
    // The count saturates, so a timeout reached mid-sweep still cancels at the sweep end.
    assign w_cancel = w_step && w_turn && r_seq == SEQ_LAST && !w_db[DB_H] &&
                      int'(r_turn_cnt) >= CANCEL_STEPS - 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_turn_cnt <= '0;
            r_lock_l   <= 1'b0;
            r_lock_r   <= 1'b0;
        end else begin
            r_turn_cnt <= (w_nxt != r_state || !w_turn) ? '0 :
                          (w_step && int'(r_turn_cnt) < CANCEL_STEPS) ? r_turn_cnt + 1'b1 : r_turn_cnt;
            r_lock_l   <= (w_cancel && r_state == LEFT) || (r_lock_l && w_db[DB_L]);
            r_lock_r   <= (w_cancel && r_state == RIGHT) || (r_lock_r && w_db[DB_R]);
        end
    end
`else
    assign w_l      = w_db[DB_L];
    assign w_r      = w_db[DB_R];
    assign w_cancel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_cnt <= '0;
            r_pwm      <= '0;
            r_step_en  <= 1'b0;
            r_state    <= IDLE;
            r_seq      <= '0;
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_hazard   <= 1'b0;
            r_brake    <= 1'b0;
            r_run      <= 1'b0;
            r_dim      <= 1'b0;
        end else begin
            r_step_cnt <= w_step ? '0 : r_step_cnt + 1'b1;
            r_pwm      <= r_pwm + 1'b1;
            r_step_en  <= w_step;
            r_state    <= w_nxt;
            r_seq      <= w_seq_nxt;
            r_left     <= w_nxt == LEFT;
            r_right    <= w_nxt == RIGHT;
            r_hazard   <= w_nxt == HAZ;
            r_brake    <= w_db[DB_B];
            r_run      <= w_db[DB_RUN];
            r_dim      <= w_db[DB_RUN] && int'(r_pwm) < DIM_DUTY;
        end
    end

    assign step_en = r_step_en;
    assign left    = r_left;
    assign right   = r_right;
    assign hazard  = r_hazard;
    assign brake   = r_brake;
    assign run     = r_run;
    assign dim_on  = r_dim;
    assign seq_pos = r_seq;
endmodule

// File: tb/tb_lamp_request_scheduler.sv
// tb_lamp_request_scheduler: directed and randomized switch activity checked every cycle against a behavioural model.
module tb_lamp_request_scheduler;
    import lamp_pkg::*;

    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] raw = '0;
    logic       step_en, left, right, hazard, brake, run, dim_on;
    logic [1:0] seq_pos;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_edge  = 0;
    bit         raw_h[5][MAXC];
    logic [4:0] m_db;
    int         m_own, m_pos;
    logic       e_step, e_brake, e_run, e_dim;
    int         hold[5];

    always #5 clk = ~clk;

    lamp_request_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .left_in  (raw[0]),
        .right_in (raw[1]),
        .brake_in (raw[2]),
        .hazard_in(raw[3]),
        .run_in   (raw[4]),
        .step_en  (step_en),
        .left     (left),
        .right    (right),
        .hazard   (hazard),
        .brake    (brake),
        .run      (run),
        .dim_on   (dim_on),
        .seq_pos  (seq_pos)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, n_edge);
        end
    endtask

    function automatic bit raw_at(input int i, input int k);
        return (k <= 0) ? 1'b0 : raw_h[i][k];
    endfunction

    // Owner codes: 0 none, 1 left, 2 right, 3 hazard.
    function automatic int pick(input logic [4:0] d);
        if (d[3] || (d[0] && d[1])) return 3;
        if (d[0]) return 1;
        if (d[1]) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        n_edge  = 0;
        m_db    = '0;
        m_own   = 0;
        m_pos   = 0;
        e_step  = 1'b0;
        e_brake = 1'b0;
        e_run   = 1'b0;
        e_dim   = 1'b0;
    endtask

    task automatic model_edge();
        logic [4:0] d;
        bit         ev;
        bit         all_diff;
        d = m_db;
        n_edge++;
        for (int i = 0; i < 5; i++) raw_h[i][n_edge] = raw[i];
        e_step = (n_edge % STEP_DIV_D) == 0;
        if (e_step) begin
            if (m_own == 0) ev = 1'b1;
            else if (m_own == 3) ev = !d[3] && !(d[0] && d[1]);
            else ev = d[3] || m_pos == 2;
            if (ev) begin
                m_own = pick(d);
                m_pos = 0;
            end else if (m_own != 3) begin
                m_pos++;
            end
        end
        e_brake = d[2];
        e_run   = d[4];
        e_dim   = d[4] && (((n_edge - 1) % (1 << PWM_BITS_D)) < DIM_DUTY_D);
        // The synchronized input lags the raw pin by two edges; it must disagree for DEB_CYCLES edges.
        for (int i = 0; i < 5; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB_CYCLES_D; j++)
                if (raw_at(i, n_edge - 2 - j) == m_db[i]) all_diff = 1'b0;
            if (all_diff) m_db[i] = ~m_db[i];
        end
    endtask

    task automatic check_all();
        chk("step_en", int'(step_en), int'(e_step));
        chk("left",    int'(left),    int'(m_own == 1));
        chk("right",   int'(right),   int'(m_own == 2));
        chk("hazard",  int'(hazard),  int'(m_own == 3));
        chk("seq_pos", int'(seq_pos), m_pos);
        chk("brake",   int'(brake),   int'(e_brake));
        chk("run",     int'(run),     int'(e_run));
        chk("dim_on",  int'(dim_on),  int'(e_dim));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    task automatic cycle();
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive_random();
        for (int i = 0; i < 5; i++) begin
            if (hold[i] == 0) begin
                raw[i]  = (i == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
                hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(10, 160));
            end else begin
                hold[i]--;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) hold[i] = 0;
        do_reset();
        repeat (100) cycle();
        raw[0] = 1'b1;
        repeat (2) cycle();
        raw[0] = 1'b0;
        repeat (20) cycle();
        raw[0] = 1'b1;
        raw[4] = 1'b1;
        repeat (70) cycle();
        raw[1] = 1'b1;
        raw[0] = 1'b0;
        repeat (60) cycle();
        raw[0] = 1'b1;
        raw[1] = 1'b0;
        repeat (40) cycle();
        raw[3] = 1'b1;
        repeat (40) cycle();
        raw[3] = 1'b0;
        repeat (40) cycle();
        raw[2] = 1'b1;
        repeat (12) cycle();
        raw[2] = 1'b0;
        repeat (3000) begin
            drive_random();
            cycle();
        end
        do_reset();
        repeat (2500) begin
            drive_random();
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lamp_request_scheduler.md
Name: lamp_request_scheduler

Overview:
Sequences and arbitrates the tail-light request inputs ahead of the six-lamp pattern state machine.
- Debounces the raw switches.
- Generates the step-rate clock enable that paces the pattern sequence.
- Grants turn/hazard ownership so a started 3-step sweep always completes before another request takes over.
- Produces the PWM dim enable for running lights.
- Its qualified outputs drive the pattern FSM's left/right/brake/hazard/run inputs and its dim input.

Parameters:
- STEP_DIV, 16: clk cycles per step_en pulse (>=2).
- DEB_CYCLES, 4: consecutive cycles a raw input must differ from its debounced value before the debounced value follows (>=1).
- PWM_BITS, 4: width of the free-running dim PWM counter.
- DIM_DUTY, 3: dim_on is high while pwm_cnt < DIM_DUTY (0 = never, 2^PWM_BITS = always).
- CANCEL_STEPS, 24: auto-cancel timeout in steps. Used only with the optional feature.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- left_in, right_in, brake_in, hazard_in, run_in, in, 1 each: raw switch inputs, asynchronous to clk.
- step_en, out, 1: one-cycle pulse; clock enable for the pattern FSM.
- left, right, hazard, out, 1 each: granted requests, one-hot or all zero.
- brake, run, out, 1 each: debounced pass-through.
- dim_on, out, 1: PWM dim enable, already gated by run.
- seq_pos, out, 2: step index within the current sweep, 0..2.

Behaviour:
- Reset:
  - All outputs 0.
  - Debounced values 0; all counters 0.
  - Arbiter state IDLE; seq_pos 0.
  - Takes effect mid-sequence with no completion of the sweep.
- Synchronizer: each raw input passes through a 2-flop synchronizer before the debouncer (2 cycles of latency).
- Debounce:
  - Per input, cnt increments each cycle while sync != db and clears when they are equal.
  - When cnt == DEB_CYCLES-1 and the values still differ, db <= sync and cnt <= 0.
  - A glitch shorter than DEB_CYCLES cycles never reaches db.
- Step timer:
  - step_cnt counts 0..STEP_DIV-1 and wraps.
  - step_en is registered and high exactly in the cycle after step_cnt == STEP_DIV-1.
- Arbiter FSM (states IDLE, LEFT, RIGHT, HAZ) changes state only on cycles where the internal step strobe is asserted. "Evaluate" means, in this priority order:
  - hazard_db, or left_db && right_db -> HAZ.
  - else left_db -> LEFT.
  - else right_db -> RIGHT.
  - else IDLE.
  - seq_pos <= 0 on every evaluation.
- IDLE: evaluate on each step.
- LEFT / RIGHT:
  - On a step with seq_pos < 2: seq_pos++.
  - On a step with seq_pos == 2: evaluate. A held request restarts its sweep; the opposite side may take over only here.
  - Releasing the owning switch mid-sweep does not stop it; the sweep finishes.
  - hazard_db preempts on the next step regardless of seq_pos.
- HAZ: on each step, if hazard_db == 0 and !(left_db && right_db), evaluate; otherwise stay.
- Output registers:
  - left = (state == LEFT); right = (state == RIGHT); hazard = (state == HAZ).
  - brake = brake_db and run = run_db. These are not step-gated: brake reaches the pattern FSM within 1 cycle of debounce.
  - Simultaneous brake with a turn grant: both asserted. The pattern FSM resolves the combined pattern.
- Dim PWM:
  - pwm_cnt is free-running, PWM_BITS wide, and wraps.
  - dim_on registered = run_db && (pwm_cnt < DIM_DUTY).

Optional Feature:
- Macro: LAMP_AUTO_CANCEL_EN.
- With the macro defined:
  - A step counter counts consecutive steps in LEFT or RIGHT.
  - On reaching CANCEL_STEPS, the state is forced to IDLE at the next sweep end, and that side is locked out.
  - The lockout clears when the side's db goes 0.
  - While locked, evaluation treats that side's db as 0.
  - HAZ is never cancelled.
- With the macro undefined: no counter, no lockout; turn grants persist indefinitely.

Decomposition:
- Shared package lamp_pkg holds:
  - Arbiter state encoding (IDLE=2'd0, LEFT=2'd1, RIGHT=2'd2, HAZ=2'd3).
  - SEQ_LAST=2'd2.
  - Default parameter constants, also used by the pattern FSM and the bench.
- One sub-module: lamp_debounce, holding the synchronizer plus debouncer for one bit, parameterised by DEB_CYCLES. It is instantiated 5 times.

Test Plan:
1. Reset then idle 100 cycles -> step_en pulses every 16 cycles; all grants 0; dim_on 0.
2. left_in high for 2 cycles (glitch) -> left never asserts. left_in held -> left asserts on the first step after the debounce (2 sync + 4 cycles); seq_pos steps 0,1,2,0 on successive step_en pulses.
3. LEFT at seq_pos 0, then right_in asserted and left_in released -> left stays high through seq_pos 2; right asserts on the following step.
4. LEFT at seq_pos 1, then hazard_in asserted -> hazard=1, left=0, seq_pos=0 on the next step. Releasing hazard_in while left_in is held -> LEFT on the next step.
5. run_in high with defaults -> dim_on high for 3 of every 16 cycles. brake_in high -> brake high within 7 cycles, independent of step_en.
6. With LAMP_AUTO_CANCEL_EN and right_in held -> right drops after the sweep end that reaches 24 steps and stays 0 until right_in goes low then high again.
